bit_stuff_tx: RTL and testbench

- Serial transmitter that produces the line bitstream consumed by the team's serial run-length detectors.
- Accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock.
- Inserts a complement "stuff" bit after every RUN_MAX identical consecutive line bits, so the line never carries a run longer than RUN_MAX.
- Between words, drives an alternating idle fill, so the stuffing guarantee holds at all times.

---
 rtl/bit_stuff_tx_pkg.sv | 19 +
 rtl/stuff_run_counter.sv | 51 +++++
 rtl/bit_stuff_tx.sv | 124 ++++++++++++
 tb/tb_bit_stuff_tx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_stuff_tx_pkg.sv
// Shared definitions for the bit-stuffing transmitter and its companion
// destuffing receiver.
//
// Contents:
//   state_e          - transmitter line-slot state (IDLE, SHIFT, STUFF)
//   WIDTH_DEFAULT    - default parallel word width
//   RUN_MAX_DEFAULT  - default longest run of identical line bits
package bit_stuff_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STUFF = 2'd2
  } state_e;

  localparam int WIDTH_DEFAULT   = 8;
  localparam int RUN_MAX_DEFAULT = 3;

endpackage

// File: rtl/stuff_run_counter.sv
// Tracks the run of identical consecutive bits on a serial line.
// Shared by the stuffing transmitter and the destuffing receiver so that
// both ends agree exactly on when a stuff bit is owed.
//
// Ports:
//   clk         - clock, rising edge
//   reset       - synchronous active-high reset (last bit 0, run length 1)
//   bit_en_i    - a new line bit is being registered this edge
//   bit_i       - value of that new line bit
//   last_bit_o  - most recent line bit
//   run_len_o   - identical consecutive bits ending at last_bit_o (saturating)
//   at_limit_o  - run_len_o has reached RUN_MAX
module stuff_run_counter
  import bit_stuff_tx_pkg::*;
#(
  parameter int RUN_MAX = RUN_MAX_DEFAULT,
  localparam int RW     = $clog2(RUN_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bit_en_i,
  input  logic          bit_i,
  output logic          last_bit_o,
  output logic [RW-1:0] run_len_o,
  output logic          at_limit_o
);

  logic          lastBit_q;
  logic [RW-1:0] runLen_q;

  // A differing bit restarts the run; an equal bit extends it, saturating
  // at RUN_MAX since nothing downstream needs to count further.
  always_ff @(posedge clk) begin
    if (reset) begin
      lastBit_q <= 1'b0;
      runLen_q  <= RW'(1);
    end else if (bit_en_i) begin
      lastBit_q <= bit_i;
      if (bit_i != lastBit_q) begin
        runLen_q <= RW'(1);
      end else if (runLen_q != RW'(RUN_MAX)) begin
        runLen_q <= runLen_q + RW'(1);
      end
    end
  end

  assign last_bit_o = lastBit_q;
  assign run_len_o  = runLen_q;
  assign at_limit_o = (runLen_q == RW'(RUN_MAX));

endmodule

// File: rtl/bit_stuff_tx.sv
// Bit-stuffing serial transmitter. Accepts parallel words over valid/ready,
// shifts them out MSB-first one bit per clock, inserts a complement stuff
// bit whenever the line run reaches RUN_MAX, and drives alternating idle
// fill between words so the line never carries more than RUN_MAX
// identical bits.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous active-high reset
//   in_data    - word to send, sampled on handshake
//   in_valid   - in_data is valid
//   in_ready   - a word can be accepted this cycle (combinational)
//   out        - serial line bit (registered)
//   out_valid  - out is a data bit (registered)
//   out_stuff  - out is a stuff bit (registered); neither flag = idle fill
module bit_stuff_tx
  import bit_stuff_tx_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int RUN_MAX = RUN_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic             out_stuff
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(RUN_MAX + 1);

  // state_q describes the slot currently on the line; bitsLeft_q counts
  // data bits of the word still to be sent after it.
  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bitsLeft_q, bitsLeft_d;
  logic             out_q, out_d;
  logic             outValid_q, outValid_d;
  logic             outStuff_q, outStuff_d;

  logic             lastBit;
  logic [RW-1:0]    runLenUnused;
  logic             atLimit;
  logic             accept;

  // The counter sees every bit as it is registered onto the line, so its
  // last bit always matches out and its run length describes the line.
  stuff_run_counter #(
    .RUN_MAX(RUN_MAX)
  ) u_runCounter (
    .clk       (clk),
    .reset     (reset),
    .bit_en_i  (1'b1),
    .bit_i     (out_d),
    .last_bit_o(lastBit),
    .run_len_o (runLenUnused),
    .at_limit_o(atLimit)
  );

  // Ready in idle, or in the final slot of a word: the last data bit when
  // no stuff bit is owed after it, or the trailing stuff bit.
  assign in_ready = (state_q == IDLE)
                 || ((state_q == SHIFT) && (bitsLeft_q == '0) && !atLimit)
                 || ((state_q == STUFF) && (bitsLeft_q == '0));

  assign accept = in_valid && in_ready;

  // Choose the next line slot. A new word goes straight onto the line so
  // words follow each other with no gap; an owed stuff bit always wins
  // over the next data bit; otherwise idle fill inverts the last bit.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitsLeft_d = bitsLeft_q;
    out_d      = ~lastBit;
    outValid_d = 1'b0;
    outStuff_d = 1'b0;
    if (accept) begin
      state_d    = SHIFT;
      out_d      = in_data[WIDTH-1];
      outValid_d = 1'b1;
      shift_d    = {in_data[WIDTH-2:0], 1'b0};
      bitsLeft_d = BW'(WIDTH - 1);
    end else if ((state_q == SHIFT) && atLimit) begin
      state_d    = STUFF;
      outStuff_d = 1'b1;
    end else if ((state_q != IDLE) && (bitsLeft_q != '0)) begin
      state_d    = SHIFT;
      out_d      = shift_q[WIDTH-1];
      outValid_d = 1'b1;
      shift_d    = {shift_q[WIDTH-2:0], 1'b0};
      bitsLeft_d = bitsLeft_q - BW'(1);
    end else begin
      state_d = IDLE;
    end
  end

  // Reset discards any word in flight and parks the line at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bitsLeft_q <= '0;
      out_q      <= 1'b0;
      outValid_q <= 1'b0;
      outStuff_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitsLeft_q <= bitsLeft_d;
      out_q      <= out_d;
      outValid_q <= outValid_d;
      outStuff_q <= outStuff_d;
    end
  end

  assign out       = out_q;
  assign out_valid = outValid_q;
  assign out_stuff = outStuff_q;

endmodule

// File: tb/tb_bit_stuff_tx.sv
// Testbench for bit_stuff_tx. Directed words carry hand-computed line
// sequences pushed to a scoreboard; a monitor checks every line slot
// against it, checks idle alternation, the run limit, and reassembles
// destuffed data bits into words for comparison. A random phase then
// streams words with gaps through the same monitor.
module tb_bit_stuff_tx;

  localparam int WIDTH   = 8;
  localparam int RUN_MAX = 3;

  typedef struct packed {
    logic o;
    logic s;
    logic r;
  } lineExp_t;

  logic             clk      = 1'b0;
  logic             reset    = 1'b1;
  logic [WIDTH-1:0] in_data  = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             out;
  logic             out_valid;
  logic             out_stuff;

  lineExp_t         bitQ[$];
  logic [WIDTH-1:0] wordQ[$];
  int               compared   = 0;
  int               mismatched = 0;
  logic             bitCheckEn = 1'b1;

  logic             prevOut     = 1'b0;
  logic             prevKnown   = 1'b0;
  int               runCount    = 1;
  logic [WIDTH-1:0] collectWord = '0;
  int               collectCnt  = 0;
  lineExp_t         expBit;
  logic             expIdle;

  bit_stuff_tx #(
    .WIDTH  (WIDTH),
    .RUN_MAX(RUN_MAX)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .out_valid(out_valid),
    .out_stuff(out_stuff)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Push a hand-computed line sequence, first slot in bit n-1.
  task automatic pushBits(input int n, input logic [31:0] o, input logic [31:0] s,
                          input logic [31:0] r);
    lineExp_t e;
    for (int i = n - 1; i >= 0; i--) begin
      e.o = o[i];
      e.s = s[i];
      e.r = r[i];
      bitQ.push_back(e);
    end
  endtask

  // Offer a word and hold it until the handshake edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic pushWord);
    logic got;
    got      = 1'b0;
    in_data  = data;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL acceptTimeout: word %0h never accepted", data);
      in_valid = 1'b0;
    end else begin
      if (pushWord) wordQ.push_back(data);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  // Return at a negedge where the line idles at 0 and a word can be taken.
  task automatic waitIdleZero();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready && !out_valid && !out_stuff && (out == 1'b0)) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL idleWait: line never idled at 0");
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300; i++) begin
      if ((bitQ.size() == 0) && (wordQ.size() == 0)) break;
      @(negedge clk);
    end
    checkOutput("bitQueueEmpty", bitQ.size(), 0);
    checkOutput("wordQueueEmpty", wordQ.size(), 0);
  endtask

  // Monitor: every line slot outside reset is checked.
  always @(negedge clk) begin
    if (reset) begin
      collectCnt = 0;
      prevOut    = out;
      prevKnown  = 1'b1;
      runCount   = 1;
    end else begin
      if (prevKnown && (out === prevOut)) runCount++;
      else runCount = 1;
      compared++;
      if (runCount > RUN_MAX) begin
        mismatched++;
        $display("[TB] FAIL runLimit: run of %0d identical bits, allowed %0d", runCount, RUN_MAX);
      end
      if (!out_valid && !out_stuff) begin
        expIdle = ~prevOut;
        if (prevKnown) checkOutput("idleAlternate", out, expIdle);
        checkOutput("idleReady", in_ready, 1);
      end else begin
        checkOutput("validStuffExclusive", out_valid & out_stuff, 0);
        if (bitCheckEn) begin
          if (bitQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpectedBit: out=%0b valid=%0b stuff=%0b", out, out_valid, out_stuff);
          end else begin
            expBit = bitQ.pop_front();
            checkOutput("lineBit", out, expBit.o);
            checkOutput("stuffFlag", out_stuff, expBit.s);
            checkOutput("readyFlag", in_ready, expBit.r);
          end
        end
      end
      if (out_valid) begin
        collectWord = {collectWord[WIDTH-2:0], out};
        collectCnt++;
        if (collectCnt == WIDTH) begin
          collectCnt = 0;
          if (wordQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpectedWord: got %0h with none expected", collectWord);
          end else begin
            checkOutput("destuffedWord", collectWord, wordQ.pop_front());
          end
        end
      end
      prevOut = out;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]       idlePat;
    logic [WIDTH-1:0] rnd;
    int               gap;

    // Reset held two cycles, then free-running idle fill 1,0,1,0.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetOut", out, 0);
    checkOutput("resetValid", out_valid, 0);
    checkOutput("resetStuff", out_stuff, 0);
    checkOutput("resetReady", in_ready, 1);
    #1 reset = 1'b0;
    idlePat = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("postResetIdle", out, idlePat[3-k]);
      checkOutput("postResetValid", out_valid, 0);
    end

    // 8'hA5 after a 0: no runs reach the limit.
    waitIdleZero();
    pushBits(8, 32'b10100101, 32'b0, 32'b00000001);
    applyStimulus(8'hA5, 1'b1);
    waitDrain();

    // 8'hFF after a 0: two mid-word stuff bits, none trailing.
    waitIdleZero();
    pushBits(10, 32'b1110111011, 32'b0001000100, 32'b0000000001);
    applyStimulus(8'hFF, 1'b1);
    waitDrain();

    // Back-to-back 8'hFF then 8'h00, gapless across the word boundary.
    waitIdleZero();
    pushBits(20, 32'b11101110110001000100, 32'b00010001000001000100,
             32'b00000000010000000001);
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'h00, 1'b1);
    waitDrain();

    // Reset during the 4th data bit of 8'hFF discards the rest of the word.
    waitIdleZero();
    pushBits(5, 32'b11101, 32'b00010, 32'b00000);
    applyStimulus(8'hFF, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midResetOut", out, 0);
    checkOutput("midResetValid", out_valid, 0);
    checkOutput("midResetStuff", out_stuff, 0);
    checkOutput("midResetReady", in_ready, 1);
    #1 reset = 1'b0;
    repeat (12) @(negedge clk);
    waitDrain();

    // Random words with random gaps: run limit and destuffed order.
    bitCheckEn = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(posedge clk);
      #1;
      rnd = WIDTH'($urandom);
      applyStimulus(rnd, 1'b1);
    end
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
